// File: rtl/homo_offset_decimator.sv
// Removes the exp(0) DC bias from the envelope stream and block-averages 2**LOG2_DEC samples.
// Optional macro SAT_EN: clamp the average into DATA_W bits instead of wrapping.
module homo_offset_decimator #(
    parameter int                DATA_W   = 32,
    parameter int                LOG2_DEC = 3,
    parameter logic [DATA_W-1:0] OFFSET   = DATA_W'(32'h0400_0000)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_data_tdata,
    input  logic              s_axis_data_tvalid,
    output logic              s_axis_data_tready,
    output logic [DATA_W-1:0] m_axis_data_tdata,
    output logic              m_axis_data_tvalid,
    input  logic              m_axis_data_tready
);

    localparam int D     = 1 << LOG2_DEC;
    localparam int ACC_W = DATA_W + 1 + LOG2_DEC;
    localparam int CNT_W = (LOG2_DEC > 0) ? LOG2_DEC : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(D - 1);

    logic                     acceptIn;
    logic                     lastPhase;
    logic                     loadResult;
    logic signed [DATA_W:0]   diff;
    logic signed [ACC_W-1:0]  accSum;
    logic signed [DATA_W:0]   result;
    logic [DATA_W-1:0]        narrowed;

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]        outData_q, outData_d;
    logic                     outValid_q, outValid_d;

    // Gated by aresetn so upstream sees no readiness while the block is held in reset.
    assign s_axis_data_tready = aresetn & (~outValid_q | m_axis_data_tready);
    assign acceptIn           = s_axis_data_tvalid & s_axis_data_tready;
    assign lastPhase          = (cnt_q == LAST);
    assign loadResult         = acceptIn & lastPhase;

    assign diff   = $signed({s_axis_data_tdata[DATA_W-1], s_axis_data_tdata})
                  - $signed({1'b0, OFFSET});
    assign accSum = acc_q + ACC_W'(diff);
    assign result = (DATA_W + 1)'(accSum >>> LOG2_DEC);

    always_comb begin
        narrowed = DATA_W'(result);
`ifdef SAT_EN
        if (result[DATA_W] != result[DATA_W-1]) begin
            narrowed = result[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        outData_d  = outData_q;
        outValid_d = outValid_q & ~m_axis_data_tready;
        if (acceptIn) begin
            if (lastPhase) begin
                acc_d      = '0;
                cnt_d      = '0;
                outData_d  = narrowed;
                outValid_d = 1'b1;
            end else begin
                acc_d = accSum;
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (!loadResult && outValid_q && !m_axis_data_tready) begin
            outData_d = outData_q;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
        end
    end

    assign m_axis_data_tdata  = outData_q;
    assign m_axis_data_tvalid = outValid_q;

endmodule

// File: tb/tb_homo_offset_decimator.sv
// Directed bench for homo_offset_decimator (DATA_W=32, LOG2_DEC=3); honours SAT_EN like the design.
module tb_homo_offset_decimator;

    localparam logic [31:0] OFFSET = 32'h0400_0000;

    logic        aclk;
    logic        aresetn;
    logic [31:0] sTdata;
    logic        sTvalid;
    logic        sTready;
    logic [31:0] mData;
    logic        mValid;
    logic        mReady;

    int checks = 0;
    int errors = 0;

    logic        monEn = 1'b0;
    logic [31:0] monQ[$];
    logic [31:0] expQ[$];
    logic        randDone;

    typedef struct {
        string       name;
        logic [31:0] base;
        logic [31:0] step;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs[6];

    homo_offset_decimator #(
        .DATA_W  (32),
        .LOG2_DEC(3),
        .OFFSET  (OFFSET)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .s_axis_data_tdata (sTdata),
        .s_axis_data_tvalid(sTvalid),
        .s_axis_data_tready(sTready),
        .m_axis_data_tdata (mData),
        .m_axis_data_tvalid(mValid),
        .m_axis_data_tready(mReady)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Output handshakes complete on the following rising edge; values are stable at the falling edge.
    always @(negedge aclk) begin
        if (monEn && mValid && mReady) monQ.push_back(mData);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Offers one sample and returns #1 after the edge that accepted it, leaving tvalid high.
    task automatic applyStimulus(input logic [31:0] value);
        logic rdy;
        int   waitCycles;
        waitCycles = 0;
        sTdata  = value;
        sTvalid = 1'b1;
        do begin
            @(negedge aclk);
            rdy = sTready;
            @(posedge aclk);
            #1;
            waitCycles++;
        end while (!rdy && waitCycles < 200);
        if (!rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept-timeout: got no accept, expected accept of %h", value);
        end
    endtask

    function automatic logic [31:0] narrowRef(input longint r);
        longint maxV;
        longint minV;
        maxV = 64'sd2147483647;
        minV = -64'sd2147483648;
`ifdef SAT_EN
        if (r > maxV) return 32'h7FFF_FFFF;
        if (r < minV) return 32'h8000_0000;
`else
        if (r > maxV || r < minV) return r[31:0];
`endif
        return r[31:0];
    endfunction

    task automatic doReset(input int cycles);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        repeat (cycles) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"dc16",     32'h0400_0010, 32'd0, 32'h0000_0010};
        vecs[1] = '{"ramp",     OFFSET,        32'd1, 32'h0000_0003};
        vecs[2] = '{"minus1",   32'h03FF_FFFF, 32'd0, 32'hFFFF_FFFF};
        vecs[3] = '{"negfloor", 32'h03FF_FFF8, 32'd1, 32'hFFFF_FFFB};
        vecs[4] = '{"maxpos",   32'h7FFF_FFFF, 32'd0, 32'h7BFF_FFFF};
`ifdef SAT_EN
        vecs[5] = '{"minneg",   32'h8000_0000, 32'd0, 32'h8000_0000};
`else
        vecs[5] = '{"minneg",   32'h8000_0000, 32'd0, 32'h7C00_0000};
`endif

        aresetn = 1'b0;
        sTdata  = '0;
        sTvalid = 1'b0;
        mReady  = 1'b1;
        @(negedge aclk);
        checkOutput("reset tvalid", {31'b0, mValid}, 32'd0);
        checkOutput("reset tdata", mData, 32'd0);
        checkOutput("reset s_tready", {31'b0, sTready}, 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Table vectors: eight back-to-back samples per block, one average out.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 8; i++) begin
                applyStimulus(vecs[v].base + vecs[v].step * 32'(i));
                if (i == 6) checkOutput({vecs[v].name, " early-valid"}, {31'b0, mValid}, 32'd0);
            end
            sTvalid = 1'b0;
            checkOutput({vecs[v].name, " valid"}, {31'b0, mValid}, 32'd1);
            checkOutput({vecs[v].name, " data"}, mData, vecs[v].expected);
            @(posedge aclk);
            #1;
        end

        // Backpressure: stall the first output for ten cycles while 24 samples stream in.
        monQ.delete();
        monEn = 1'b1;
        fork
            begin
                for (int i = 0; i < 24; i++) applyStimulus(OFFSET + 32'd5);
                sTvalid = 1'b0;
            end
            begin
                int n;
                n = 0;
                do begin
                    @(posedge aclk);
                    #1;
                    n++;
                end while (!mValid && n < 200);
                mReady = 1'b0;
                checkOutput("stall seen output", {31'b0, mValid}, 32'd1);
                for (int c = 0; c < 10; c++) begin
                    @(negedge aclk);
                    checkOutput("stall s_tready", {31'b0, sTready}, 32'd0);
                    checkOutput("stall tvalid", {31'b0, mValid}, 32'd1);
                    checkOutput("stall tdata", mData, 32'd5);
                end
                @(posedge aclk);
                #1;
                mReady = 1'b1;
            end
        join
        repeat (5) @(posedge aclk);
        #1;
        checkOutput("stall output count", 32'(monQ.size()), 32'd3);
        foreach (monQ[k]) checkOutput("stall output value", monQ[k], 32'd5);
        monEn = 1'b0;

        // Reset in the middle of a block discards the partial sum.
        for (int i = 0; i < 5; i++) applyStimulus(OFFSET + 32'd9);
        sTvalid = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(negedge aclk);
        checkOutput("midreset tvalid", {31'b0, mValid}, 32'd0);
        checkOutput("midreset s_tready", {31'b0, sTready}, 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        monQ.delete();
        monEn = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(OFFSET + 32'd2);
        sTvalid = 1'b0;
        checkOutput("postreset data", mData, 32'd2);
        repeat (4) @(posedge aclk);
        #1;
        checkOutput("postreset output count", 32'(monQ.size()), 32'd1);
        monEn = 1'b0;

        // Reset while an output is pending drops it.
        mReady = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(OFFSET + 32'd40);
        sTvalid = 1'b0;
        checkOutput("pending data", mData, 32'd40);
        aresetn = 1'b0;
        #1;
        checkOutput("pending reset tvalid", {31'b0, mValid}, 32'd0);
        checkOutput("pending reset tdata", mData, 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        mReady  = 1'b1;

        // Random gaps and backpressure against a floor-average model.
        monQ.delete();
        expQ.delete();
        monEn    = 1'b1;
        randDone = 1'b0;
        fork
            begin
                longint acc;
                logic [31:0] v;
                acc = 0;
                for (int i = 0; i < 800; i++) begin
                    if ($urandom_range(1) == 1) begin
                        sTvalid = 1'b0;
                        @(posedge aclk);
                        #1;
                    end
                    v = $urandom;
                    acc += longint'($signed(v)) - longint'(OFFSET);
                    if (i % 8 == 7) begin
                        expQ.push_back(narrowRef(acc >>> 3));
                        acc = 0;
                    end
                    applyStimulus(v);
                end
                sTvalid  = 1'b0;
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    @(posedge aclk);
                    #1;
                    mReady = ($urandom_range(1) == 1);
                end
                mReady = 1'b1;
            end
        join
        for (int n = 0; n < 300 && monQ.size() < 100; n++) @(posedge aclk);
        #1;
        checkOutput("random output count", 32'(monQ.size()), 32'd100);
        for (int k = 0; k < 100 && k < monQ.size(); k++) checkOutput("random output value", monQ[k], expQ[k]);
        monEn = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
